// File: rtl/four_bit_divider_pkg.sv
// Shared definitions for the restoring divider: FSM states and default widths.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_W     = 4;
  localparam int DEF_DW    = 2 * DEF_W;
  localparam int DEF_CNT_W = $clog2(DEF_DW);

endpackage

// File: rtl/four_bit_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract divisor.
module div_step #(
  parameter int W = 4
) (
  input  logic [W:0]   pr,
  input  logic         din,
  input  logic [W-1:0] divisor,
  output logic [W:0]   pr_nxt,
  output logic         q_bit
);

  logic [W+1:0] trial;

  // Full-width compare keeps pr[W] in play even though a restoring remainder never sets it.
  always_comb begin
    trial  = {pr, din};
    q_bit  = (trial >= {2'b00, divisor});
    pr_nxt = q_bit ? (trial[W:0] - {1'b0, divisor}) : trial[W:0];
  end

endmodule

// File: rtl/four_bit_divider.sv
// Iterative unsigned divider, 2*W-bit dividend by W-bit divisor, one quotient bit per cycle.
// Result valid 2*W edges after accept (1 edge for divide-by-zero); held in DONE until out_ready.
module four_bit_divider
  import div_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic            CLK,
  input  logic            nrst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*W-1:0]  dividend,
  input  logic [W-1:0]    divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  quotient,
  output logic [W-1:0]    remainder,
  output logic            div_by_zero
);

  localparam int DW    = 2 * W;
  localparam int CNT_W = $clog2(DW);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    dvd_q, dvd_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic [W:0]       pr_q, pr_d;
  logic [DW-1:0]    qacc_q, qacc_d;
  logic [DW-1:0]    quotient_q, quotient_d;
  logic [W-1:0]     remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             out_valid_q, out_valid_d;

  logic [W:0]       pr_nxt;
  logic             q_bit;

  div_step #(.W(W)) u_step (
    .pr      (pr_q),
    .din     (dvd_q[DW-1]),
    .divisor (dvs_q),
    .pr_nxt  (pr_nxt),
    .q_bit   (q_bit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    pr_d        = pr_q;
    qacc_d      = qacc_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (divisor != '0) begin
            dvd_d   = dividend;
            dvs_d   = divisor;
            pr_d    = '0;
            qacc_d  = '0;
            cnt_d   = CNT_W'(DW - 1);
            state_d = ST_BUSY;
          end else begin
            quotient_d  = '1;
            remainder_d = dividend[W-1:0];
            dbz_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        pr_d   = pr_nxt;
        dvd_d  = {dvd_q[DW-2:0], 1'b0};
        qacc_d = {qacc_q[DW-2:0], q_bit};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          quotient_d  = {qacc_q[DW-2:0], q_bit};
          remainder_d = pr_nxt[W-1:0];
          dbz_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      pr_q        <= '0;
      qacc_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      pr_q        <= pr_d;
      qacc_q      <= qacc_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_four_bit_divider.sv
// Directed and randomized checks of four_bit_divider results, latency and handshakes.
module tb_four_bit_divider;

  logic       CLK = 1'b0;
  logic       nrst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  four_bit_divider #(.W(4)) dut (
    .CLK         (CLK),
    .nrst        (nrst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, measure accept-to-valid latency, check result, then release it.
  task automatic run_op(input logic [7:0] dvd, input logic [3:0] dvs,
                        input logic [7:0] exp_q, input logic [3:0] exp_r,
                        input logic exp_dbz, input int exp_lat);
    int n;
    @(negedge CLK);
    check("idle_rdy", in_ready, 1'b1);
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    dividend = 8'h00;
    divisor  = 4'h0;
    n = 0;
    while (n < 20) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
      if (out_valid) break;
      if (in_ready !== 1'b0) begin
        check("busy_rdy", in_ready, 1'b0);
      end
    end
    check("latency", n, exp_lat);
    check("done_rdy", in_ready, 1'b0);
    check("quotient", quotient, exp_q);
    check("remainder", remainder, exp_r);
    check("dbz", div_by_zero, exp_dbz);
    out_ready = 1'b1;
    @(posedge CLK);
    #1 out_ready = 1'b0;
    @(negedge CLK);
    check("rel_valid", out_valid, 1'b0);
    check("rel_rdy", in_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rd;
    logic [3:0] rs;
    nrst      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 8'h00;
    divisor   = 4'h0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_valid", out_valid, 1'b0);
    check("rst_rdy", in_ready, 1'b1);
    check("rst_q", quotient, 8'h00);
    check("rst_r", remainder, 4'h0);
    check("rst_dbz", div_by_zero, 1'b0);
    nrst = 1'b1;

    run_op(8'hE1, 4'hF, 8'h0F, 4'h0, 1'b0, 8);
    run_op(8'h96, 4'hF, 8'h0A, 4'h0, 1'b0, 8);
    run_op(8'h36, 4'h6, 8'h09, 4'h0, 1'b0, 8);
    run_op(8'h00, 4'h9, 8'h00, 4'h0, 1'b0, 8);
    run_op(8'hFF, 4'h1, 8'hFF, 4'h0, 1'b0, 8);
    run_op(8'hFF, 4'h7, 8'h24, 4'h3, 1'b0, 8);
    run_op(8'h64, 4'h3, 8'h21, 4'h1, 1'b0, 8);
    run_op(8'hC8, 4'h0, 8'hFF, 4'h8, 1'b1, 1);
    run_op(8'h0D, 4'h4, 8'h03, 4'h1, 1'b0, 8);

    // Back-pressure: result held, new operands ignored while DONE.
    @(negedge CLK);
    dividend = 8'hFF;
    divisor  = 4'h7;
    in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    check("bp_valid0", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      dividend = 8'h36;
      divisor  = 4'h6;
      in_valid = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      check("bp_valid", out_valid, 1'b1);
      check("bp_rdy", in_ready, 1'b0);
      check("bp_q", quotient, 8'h24);
      check("bp_r", remainder, 4'h3);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK);
    #1 out_ready = 1'b0;
    @(negedge CLK);
    check("bp_rel_valid", out_valid, 1'b0);
    check("bp_rel_rdy", in_ready, 1'b1);
    check("bp_hold_q", quotient, 8'h24);
    check("bp_hold_r", remainder, 4'h3);

    // Reset in the middle of an operation discards it.
    dividend = 8'hE1;
    divisor  = 4'hF;
    in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("mid_busy_rdy", in_ready, 1'b0);
    nrst = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    nrst = 1'b1;
    check("mid_valid", out_valid, 1'b0);
    check("mid_q", quotient, 8'h00);
    check("mid_r", remainder, 4'h0);
    check("mid_rdy", in_ready, 1'b1);
    repeat (10) begin
      @(negedge CLK);
      if (out_valid) check("mid_spurious", out_valid, 1'b0);
    end
    run_op(8'h36, 4'h6, 8'h09, 4'h0, 1'b0, 8);

    for (int k = 0; k < 500; k++) begin
      rd = 8'($urandom_range(0, 255));
      rs = 4'($urandom_range(1, 15));
      run_op(rd, rs, rd / {4'h0, rs}, 4'(rd % {4'h0, rs}), 1'b0, 8);
      check("inv_prod", 32'(quotient) * 32'(rs) + 32'(remainder), 32'(rd));
      check("inv_rlt", 32'(remainder < rs), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
